als_read_scheduler: RTL and testbench

//  Sequences reads of the PmodALS light-sensor ADC over its 3-wire SPI link (cs_n, sclk, sdo).

---
 rtl/als_pkg.sv | 21 ++
 rtl/als_read_scheduler_if.sv | 23 ++
 rtl/als_spi_frame.sv | 102 ++++++++++
 rtl/als_read_scheduler.sv | 155 +++++++++++++++
 tb/tb_als_read_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/als_pkg.sv
// rtl/als_pkg.sv - shared frame geometry and state encodings for the PmodALS read scheduler
package als_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 12;
    localparam int DATA_LSB   = 5;
    localparam int DATA_W     = DATA_MSB - DATA_LSB + 1;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_FRAME,
        SCH_HOLD
    } sch_state_e;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SETUP,
        FR_SHIFT
    } fr_state_e;

endpackage

// File: rtl/als_read_scheduler_if.sv
// rtl/als_read_scheduler_if.sv - ADC pin and light-value bundle for the read scheduler
interface als_read_scheduler_if;

    logic                       sdo;
    logic                       req;
    logic                       cs_n;
    logic                       sclk;
    logic                       busy;
    logic [als_pkg::DATA_W-1:0] data;
    logic                       data_valid;
    logic                       req_done;

    modport master (
        input  sdo, req,
        output cs_n, sclk, busy, data, data_valid, req_done
    );

    modport slave (
        output sdo, req,
        input  cs_n, sclk, busy, data, data_valid, req_done
    );

endinterface

// File: rtl/als_spi_frame.sv
// rtl/als_spi_frame.sv - one 16-bit ADC frame: cs_n/sclk generation and MSB-first sdo capture
module als_spi_frame
    import als_pkg::*;
#(
    parameter int SCLK_DIV = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  sdo,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  done,
    output logic [FRAME_BITS-1:0] sample
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    fr_state_e             state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  phase_end;

    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        sr_d    = sr_q;
        done    = 1'b0;
        case (state_q)
            FR_IDLE: begin
                if (start) begin
                    state_d = FR_SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            FR_SETUP: begin
                div_d = div_q + 1'b1;
                if (phase_end) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = FR_SHIFT;
                end
            end
            FR_SHIFT: begin
                div_d = div_q + 1'b1;
                if (phase_end) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[FRAME_BITS-2:0], sdo};
                    end else if (bit_q == BIT_LAST) begin
                        // the last high phase still belongs to the frame
                        done    = 1'b1;
                        cs_n_d  = 1'b1;
                        state_d = FR_IDLE;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FR_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            sr_q    <= sr_d;
        end
    end

    assign cs_n   = cs_n_q;
    assign sclk   = sclk_q;
    assign sample = sr_q;

endmodule

// File: rtl/als_read_scheduler.sv
// rtl/als_read_scheduler.sv - periodic/on-demand PmodALS reads sharing one frame engine; ALS_AVG_EN adds 4-frame averaging
module als_read_scheduler
    import als_pkg::*;
#(
    parameter int TERM_COUNT = 1_000_000,
    parameter int SCLK_DIV   = 5,
    parameter int QUIET      = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    als_read_scheduler_if.master bus
);

    localparam int CNT_W = $clog2(TERM_COUNT);
    localparam int Q_W   = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERM_COUNT - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET - 1);

    sch_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [Q_W-1:0]        hold_q, hold_d;
    logic                  pend_auto_q, pend_auto_d;
    logic                  pend_req_q, pend_req_d;
    logic                  serve_req_q, serve_req_d;
    logic                  busy_q, busy_d;
    logic                  dv_q, dv_d;
    logic                  rd_q, rd_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  wrap;
    logic                  frame_start;
    logic                  frame_done;
    logic [FRAME_BITS-1:0] frame_sample;
    logic [DATA_W-1:0]     raw_data;
    logic [DATA_W-1:0]     new_data;
    logic                  unused_sample_bits;

    als_spi_frame #(
        .SCLK_DIV (SCLK_DIV)
    ) u_frame (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (frame_start),
        .sdo     (bus.sdo),
        .cs_n    (bus.cs_n),
        .sclk    (bus.sclk),
        .done    (frame_done),
        .sample  (frame_sample)
    );

    assign raw_data           = frame_sample[DATA_MSB:DATA_LSB];
    assign unused_sample_bits = ^{frame_sample[FRAME_BITS-1:DATA_MSB+1], frame_sample[DATA_LSB-1:0]};
    assign wrap               = (cnt_q == CNT_LAST);
    assign cnt_d              = wrap ? '0 : cnt_q + 1'b1;

`ifdef ALS_AVG_EN
    logic [2:0][DATA_W-1:0] hist_q, hist_d;
    logic [DATA_W+1:0]      avg_sum;

    assign avg_sum  = {2'b00, raw_data} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    assign new_data = avg_sum[DATA_W+1:2];

    always_comb begin
        hist_d = hist_q;
        if (frame_done) begin
            hist_d = {hist_q[1:0], raw_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign new_data = raw_data;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        // a trigger arriving this very cycle is folded into the flags, so a
        // simultaneous set and IDLE clear never loses it and IDLE starts in 1 clk
        pend_auto_d = pend_auto_q | wrap;
        pend_req_d  = pend_req_q | bus.req;
        serve_req_d = serve_req_q;
        busy_d      = busy_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        rd_d        = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            SCH_IDLE: begin
                if (pend_auto_d || pend_req_d) begin
                    frame_start = 1'b1;
                    serve_req_d = pend_req_d;
                    pend_auto_d = 1'b0;
                    pend_req_d  = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SCH_FRAME;
                end
            end
            SCH_FRAME: begin
                if (frame_done) begin
                    data_d  = new_data;
                    dv_d    = 1'b1;
                    rd_d    = serve_req_q;
                    hold_d  = '0;
                    state_d = SCH_HOLD;
                end
            end
            SCH_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == Q_LAST) begin
                    busy_d  = 1'b0;
                    state_d = SCH_IDLE;
                end
            end
            default: state_d = SCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCH_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            pend_auto_q <= 1'b0;
            pend_req_q  <= 1'b0;
            serve_req_q <= 1'b0;
            busy_q      <= 1'b0;
            dv_q        <= 1'b0;
            rd_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            pend_auto_q <= pend_auto_d;
            pend_req_q  <= pend_req_d;
            serve_req_q <= serve_req_d;
            busy_q      <= busy_d;
            dv_q        <= dv_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.req_done   = rd_q;

endmodule

// File: tb/tb_als_read_scheduler.sv
// tb/tb_als_read_scheduler.sv - directed self-checking bench for als_read_scheduler
module tb_als_read_scheduler;

    localparam int TERM_COUNT = 1000;
    localparam int SCLK_DIV   = 5;
    localparam int QUIET      = 10;
    localparam int FRAME_CLKS = SCLK_DIV * 33;

`ifdef ALS_AVG_EN
    localparam logic [7:0]  EXP_BOOT [4] = '{8'h14, 8'h29, 8'h3E, 8'h53};
    localparam logic [15:0] T6_FRAME [4] = '{16'h0A60, 16'h0A60, 16'h0A60, 16'h0A60};
    localparam logic [7:0]  T6_EXP   [4] = '{8'h14, 8'h29, 8'h3E, 8'h53};
`else
    localparam logic [7:0]  EXP_BOOT [4] = '{8'h53, 8'h53, 8'h53, 8'h53};
    localparam logic [15:0] T6_FRAME [4] = '{16'h0A60, 16'h1FE0, 16'hE01F, 16'h0A60};
    localparam logic [7:0]  T6_EXP   [4] = '{8'h53, 8'hFF, 8'h00, 8'h53};
`endif

    logic clk = 1'b0;
    logic reset_n;

    als_read_scheduler_if bus_if ();

    als_read_scheduler #(
        .TERM_COUNT (TERM_COUNT),
        .SCLK_DIV   (SCLK_DIV),
        .QUIET      (QUIET)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #50 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: shifts the current word out MSB first on sclk falls
    logic [15:0] frame_word = 16'h0A60;
    int          sdo_idx    = 15;

    always @(negedge bus_if.cs_n) sdo_idx = 15;

    always @(negedge bus_if.sclk) begin
        if (!bus_if.cs_n && sdo_idx >= 0) begin
            bus_if.sdo = frame_word[sdo_idx];
            sdo_idx--;
        end
    end

    int   low_cnt = 0, rise_cnt = 0, last_low = 0, last_rise = 0;
    int   idle_sclk_bad = 0, dv_count = 0;
    logic cs_prev = 1'b1, sclk_prev = 1'b1;

    always @(negedge clk) begin
        if (!bus_if.cs_n) begin
            if (cs_prev) begin
                low_cnt  = 1;
                rise_cnt = 0;
            end else begin
                low_cnt++;
            end
            if (bus_if.sclk && !sclk_prev) rise_cnt++;
        end else begin
            if (!cs_prev) begin
                last_low  = low_cnt;
                last_rise = rise_cnt;
            end
            if (bus_if.sclk !== 1'b1) idle_sclk_bad++;
        end
        if (bus_if.data_valid) dv_count++;
        cs_prev   = bus_if.cs_n;
        sclk_prev = bus_if.sclk;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cs_fall(input int limit, output int n);
        n = 0;
        while (bus_if.cs_n && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_dv(input int limit, output int n);
        n = 0;
        while (!bus_if.data_valid && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus_if.busy && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_req();
        bus_if.req = 1'b1;
        tick();
        bus_if.req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int dv_before;
        bus_if.req = 1'b0;
        bus_if.sdo = 1'b0;
        reset_n    = 1'b1;
        #1;
        reset_n    = 1'b0;
        #399;
        check_val("rst_cs_n", bus_if.cs_n, 1);
        check_val("rst_sclk", bus_if.sclk, 1);
        check_val("rst_busy", bus_if.busy, 0);
        check_val("rst_data", bus_if.data, 0);
        check_val("rst_data_valid", bus_if.data_valid, 0);
        check_val("rst_req_done", bus_if.req_done, 0);
        #100;
        reset_n = 1'b1;

        // first automatic conversion after release
        wait_cs_fall(1100, n);
        check_val("t1_auto_start_window", (n >= 995 && n <= 1005), 1);
        check_val("t1_busy_in_frame", bus_if.busy, 1);
        wait_dv(200, n);
        check_val("t1_cs_to_dv", n, FRAME_CLKS);
        check_val("t1_data", bus_if.data, EXP_BOOT[0]);
        check_val("t1_req_done", bus_if.req_done, 0);
        check_val("t1_cs_n_high_at_dv", bus_if.cs_n, 1);
        check_val("t2_cs_low_clks", last_low, FRAME_CLKS);
        check_val("t2_sclk_rises", last_rise, 16);
        tick();
        check_val("t1_dv_pulse_width", bus_if.data_valid, 0);

        // on-demand request while idle
        wait_idle(50);
        check_val("t3_idle_before_req", bus_if.busy, 0);
        pulse_req();
        check_val("t3_cs_fall_1clk", bus_if.cs_n, 0);
        wait_dv(200, n);
        check_val("t3_cs_to_dv", n, FRAME_CLKS);
        check_val("t3_req_done", bus_if.req_done, 1);
        check_val("t3_data", bus_if.data, EXP_BOOT[1]);
        tick();
        check_val("t3_req_done_pulse", bus_if.req_done, 0);

        // request mid-SHIFT of an automatic frame
        wait_cs_fall(1000, n);
        check_val("t4_auto_start_seen", (n < 1000), 1);
        repeat (80) tick();
        check_val("t4_busy_mid_shift", bus_if.busy, 1);
        pulse_req();
        wait_dv(200, n);
        check_val("t4_req_to_dv", n, 84);
        check_val("t4_first_req_done", bus_if.req_done, 0);
        check_val("t4_first_data", bus_if.data, EXP_BOOT[2]);
        wait_cs_fall(50, n);
        check_val("t4_gap_clks", n, QUIET + 1);
        wait_dv(200, n);
        check_val("t4_second_cs_to_dv", n, FRAME_CLKS);
        check_val("t4_second_req_done", bus_if.req_done, 1);
        check_val("t4_second_data", bus_if.data, EXP_BOOT[3]);

        // reset at the 8th sclk rise of a frame
        wait_idle(50);
        pulse_req();
        n = 0;
        while (rise_cnt < 8 && n < 200) begin
            tick();
            n++;
        end
        check_val("t5_reached_8th_rise", rise_cnt, 8);
        reset_n = 1'b0;
        #1;
        check_val("t5_abort_cs_n", bus_if.cs_n, 1);
        check_val("t5_abort_sclk", bus_if.sclk, 1);
        check_val("t5_abort_data", bus_if.data, 0);
        check_val("t5_abort_busy", bus_if.busy, 0);
        dv_before = dv_count;
        #200;
        reset_n = 1'b1;
        wait_cs_fall(1100, n);
        check_val("t5_restart_window", (n >= 995 && n <= 1005), 1);
        check_val("t5_no_dv_before_wrap", dv_count, dv_before);

        // post-reset frame sequence (averaging ramp when enabled)
        wait_dv(200, n);
        check_val("t6_f0_cs_to_dv", n, FRAME_CLKS);
        check_val("t6_f0_data", bus_if.data, T6_EXP[0]);
        check_val("t6_f0_req_done", bus_if.req_done, 0);
        for (int i = 1; i < 4; i++) begin
            wait_idle(50);
            frame_word = T6_FRAME[i];
            pulse_req();
            check_val($sformatf("t6_f%0d_cs_fall", i), bus_if.cs_n, 0);
            wait_dv(200, n);
            check_val($sformatf("t6_f%0d_cs_to_dv", i), n, FRAME_CLKS);
            check_val($sformatf("t6_f%0d_data", i), bus_if.data, T6_EXP[i]);
            check_val($sformatf("t6_f%0d_req_done", i), bus_if.req_done, 1);
        end

        tick();
        check_val("t2_sclk_high_while_cs_high", idle_sclk_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
